// File: rtl/pc_fifo.sv
// pc_fifo: parametrised valid/ready FIFO with occupancy watermarks; define PCFIFO_ERR_EN for sticky overflow/underflow flags
module pc_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH = 10,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                         iclk,
  input  logic                         irst,
  input  logic                         producer_valid,
  output logic                         producer_ready,
  input  logic [DATA_WIDTH-1:0]        producer_data,
  output logic                         consumer_valid,
  input  logic                         consumer_ready,
  output logic [DATA_WIDTH-1:0]        consumer_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         almost_empty
`ifdef PCFIFO_ERR_EN
  ,
  output logic                         overflow_err,
  output logic                         underflow_err
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic full, empty, push, pop;
`ifdef PCFIFO_ERR_EN
  logic ovf_q, ovf_d, unf_q, unf_d;
`endif
  always_comb begin
    full = count_q == FULL_CNT;
    empty = count_q == '0;
    push = producer_valid & ~full;
    pop = consumer_ready & ~empty;
    wr_ptr_d = push ? (wr_ptr_q == LAST ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q == LAST ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
`ifdef PCFIFO_ERR_EN
    ovf_d = ovf_q | (producer_valid & full);
    unf_d = unf_q | (consumer_ready & empty);
`endif
  end
  always_ff @(posedge iclk) begin
    if (irst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
`ifdef PCFIFO_ERR_EN
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
`ifdef PCFIFO_ERR_EN
      ovf_q <= ovf_d;
      unf_q <= unf_d;
`endif
    end
  end
  always_ff @(posedge iclk) begin
    if (push && !irst) mem_q[wr_ptr_q] <= producer_data;
  end
  assign producer_ready = ~full;
  assign consumer_valid = ~empty;
  assign consumer_data = mem_q[rd_ptr_q];
  assign count = count_q;
  assign almost_full = count_q >= CW'(AF_LEVEL);
  assign almost_empty = count_q <= CW'(AE_LEVEL);
`ifdef PCFIFO_ERR_EN
  assign overflow_err = ovf_q;
  assign underflow_err = unf_q;
`endif
endmodule

// File: tb/tb_pc_fifo.sv
// tb_pc_fifo: scoreboard bench for pc_fifo (DEPTH=10, DATA_WIDTH=4), error flags checked when PCFIFO_ERR_EN is defined
module tb_pc_fifo;
  logic iclk = 1'b0;
  logic irst = 1'b1;
  logic producer_valid = 1'b0;
  logic producer_ready;
  logic [3:0] producer_data = '0;
  logic consumer_valid;
  logic consumer_ready = 1'b0;
  logic [3:0] consumer_data;
  logic [3:0] count;
  logic almost_full, almost_empty;
  logic overflow_err, underflow_err;
  int total = 0;
  int bad = 0;
  logic [3:0] sb [$];
  int exp_count = 0;
  logic ovf_exp = 1'b0;
  logic unf_exp = 1'b0;
  pc_fifo dut (
    .iclk(iclk),
    .irst(irst),
    .producer_valid(producer_valid),
    .producer_ready(producer_ready),
    .producer_data(producer_data),
    .consumer_valid(consumer_valid),
    .consumer_ready(consumer_ready),
    .consumer_data(consumer_data),
    .count(count),
    .almost_full(almost_full),
    .almost_empty(almost_empty)
`ifdef PCFIFO_ERR_EN
    ,
    .overflow_err(overflow_err),
    .underflow_err(underflow_err)
`endif
  );
`ifndef PCFIFO_ERR_EN
  assign overflow_err = 1'b0;
  assign underflow_err = 1'b0;
`endif
  always #5 iclk = ~iclk;
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input logic pv, input logic [3:0] pd, input logic cr);
    logic push_ok, pop_ok;
    producer_valid = pv;
    producer_data = pd;
    consumer_ready = cr;
    check("count", 32'(count), exp_count);
    check("producer_ready", 32'(producer_ready), 32'(exp_count != 10));
    check("consumer_valid", 32'(consumer_valid), 32'(exp_count != 0));
    check("almost_full", 32'(almost_full), 32'(exp_count >= 8));
    check("almost_empty", 32'(almost_empty), 32'(exp_count <= 2));
`ifdef PCFIFO_ERR_EN
    check("overflow_err", 32'(overflow_err), 32'(ovf_exp));
    check("underflow_err", 32'(underflow_err), 32'(unf_exp));
`endif
    push_ok = pv && exp_count < 10;
    pop_ok = cr && exp_count > 0;
    if (pop_ok) check("consumer_data", 32'(consumer_data), (sb.size() > 0) ? 32'(sb.pop_front()) : -1);
    if (push_ok) sb.push_back(pd);
    ovf_exp |= pv && exp_count == 10;
    unf_exp |= cr && exp_count == 0;
    exp_count += int'(push_ok) - int'(pop_ok);
    @(posedge iclk);
    #1;
  endtask
  task automatic rst_cyc(input logic pv, input logic [3:0] pd);
    irst = 1'b1;
    producer_valid = pv;
    producer_data = pd;
    consumer_ready = 1'b1;
    @(posedge iclk);
    #1;
    irst = 1'b0;
    sb.delete();
    exp_count = 0;
    ovf_exp = 1'b0;
    unf_exp = 1'b0;
  endtask
  initial begin
    rst_cyc(1'b0, 4'h0);
    rst_cyc(1'b0, 4'h0);
    cyc(1'b0, 4'h0, 1'b0);
    for (int i = 1; i <= 10; i++) cyc(1'b1, 4'(i), 1'b0);
    cyc(1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 4'(i + 3), 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 4'(10 - i), 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 4'(i), 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 4'(i + 5), 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 4'(i + 9), 1'b0);
    cyc(1'b1, 4'hE, 1'b1);
    cyc(1'b0, 4'h0, 1'b0);
    cyc(1'b1, 4'hD, 1'b0);
    cyc(1'b1, 4'hC, 1'b0);
    cyc(1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 4'(i + 1), 1'b0);
    rst_cyc(1'b1, 4'hF);
    cyc(1'b1, 4'h5, 1'b0);
    cyc(1'b1, 4'h6, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 300; i++) cyc(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
    while (exp_count > 0) cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
